// File: rtl/fir_coeff_loader_pkg.sv
// Shared types and reset defaults for the FIR coefficient loader.
// The active bank resets to an identity filter (tap 0 = 1, multiplier = 1).
package fir_pkg;

  localparam int unsigned FIR_CW = 11;
  localparam int unsigned FIR_MW = 8;

  typedef logic signed [FIR_CW-1:0] coeff_t;
  typedef logic        [FIR_MW-1:0] mult_t;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FLUSH  = 2'd1,
    COMMIT = 2'd2
  } ldr_state_e;

  localparam int COEFF0_DEFAULT = 1;
  localparam int COEFF_DEFAULT  = 0;
  localparam int MULT_DEFAULT   = 1;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Serial configuration word stream (valid/ready) feeding the coefficient loader.
interface fir_coeff_loader_if #(
  parameter int unsigned CW = 11
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          cfg_last;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/fir_coeff_bank.sv
// N-entry shadow/active coefficient bank plus multiplier; writes land in the
// shadow copy and a single commit strobe copies everything to the active copy.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 11,
  parameter int unsigned MW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [$clog2(N+1)-1:0]     i_wr_idx,
  input  logic [CW-1:0]              i_wr_data,
  input  logic                       i_commit,
  output logic signed [CW-1:0]       o_coeff [N],
  output logic [MW-1:0]              o_mult
);

  localparam int unsigned IW = $clog2(N + 1);

  logic signed [CW-1:0] r_shadow [N];
  logic signed [CW-1:0] r_active [N];
  logic [MW-1:0]        r_shadow_mult;
  logic [MW-1:0]        r_active_mult;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= (i == 0) ? CW'(COEFF0_DEFAULT) : CW'(COEFF_DEFAULT);
      end
      r_shadow_mult <= '0;
      r_active_mult <= MW'(MULT_DEFAULT);
    end else begin
      if (i_wr_en) begin
        for (int i = 0; i < N; i++) begin
          if (i_wr_idx == IW'(i)) r_shadow[i] <= i_wr_data;
        end
        // Index N is the multiplier word; only its low MW bits are meaningful.
        if (i_wr_idx == IW'(N)) r_shadow_mult <= i_wr_data[MW-1:0];
      end
      if (i_commit) begin
        r_active      <= r_shadow;
        r_active_mult <= r_shadow_mult;
      end
    end
  end

  assign o_coeff = r_active;
  assign o_mult  = r_active_mult;

endmodule

// File: rtl/fir_coeff_loader.sv
// Frames N+1 configuration words into the shadow bank and commits them atomically,
// so the filter never observes a partially loaded coefficient set.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned CW = 11,
  parameter int unsigned MW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_coeff_loader_if.slave    cfg,
  input  logic                 i_cfg_abort,
  input  logic                 i_coeff_hold,
  output logic signed [CW-1:0] o_coefficients [N],
  output logic [MW-1:0]        o_multiplier,
  output logic                 o_coeff_update,
  output logic                 o_load_err,
  output logic                 o_busy
);

  localparam int unsigned IW = $clog2(N + 1);
  localparam logic [IW-1:0] IDX_MULT = IW'(N);

  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_FLUSH  = FLUSH;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  logic [1:0]    r_state, w_state_d;
  logic [IW-1:0] r_idx, w_idx_d;
  logic          r_upd, w_upd_d;
  logic          r_err, w_err_d;
  logic          w_wr_en, w_commit, w_xfer;

  assign cfg.cfg_ready = (r_state != ST_COMMIT);
  assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_upd_d   = 1'b0;
    w_err_d   = 1'b0;
    w_wr_en   = 1'b0;
    w_commit  = 1'b0;
    // Abort outranks everything: drops same-cycle words and any pending commit.
    if (i_cfg_abort) begin
      w_state_d = ST_LOAD;
      w_idx_d   = '0;
    end else begin
      unique case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            if (r_idx != IDX_MULT) begin
              if (cfg.cfg_last) begin
                w_err_d = 1'b1;
                w_idx_d = '0;
              end else begin
                w_wr_en = 1'b1;
                w_idx_d = r_idx + 1'b1;
              end
            end else if (cfg.cfg_last) begin
              w_wr_en   = 1'b1;
              w_idx_d   = '0;
              w_state_d = ST_COMMIT;
            end else begin
              w_err_d   = 1'b1;
              w_idx_d   = '0;
              w_state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (w_xfer && cfg.cfg_last) w_state_d = ST_LOAD;
        end
        ST_COMMIT: begin
          if (!i_coeff_hold) begin
            w_commit  = 1'b1;
            w_upd_d   = 1'b1;
            w_state_d = ST_LOAD;
          end
        end
        default: begin
          w_state_d = ST_LOAD;
          w_idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_upd   <= w_upd_d;
      r_err   <= w_err_d;
    end
  end

  fir_coeff_bank #(
    .N  (N),
    .CW (CW),
    .MW (MW)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (cfg.cfg_data),
    .i_commit  (w_commit),
    .o_coeff   (o_coefficients),
    .o_mult    (o_multiplier)
  );

  assign o_coeff_update = r_upd;
  assign o_load_err     = r_err;
  assign o_busy         = (r_state != ST_LOAD) || (r_idx != '0);

endmodule
